// File: rtl/iram_arbiter_if.sv
// IRAM arbiter bus bundle: fetch port, loader/debug port, IRAM port and
// the fetch stall indicator. The arbiter connects through the slave modport;
// requesters, the IRAM model and testbenches use the master modport.
interface iram_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  // Fetch port
  logic            f_req;
  logic [XLEN-3:0] f_addr;
  logic            f_gnt;
  logic            f_rvalid;
  logic [XLEN-1:0] f_rdata;
  // Loader / debug port
  logic            l_req;
  logic            l_we;
  logic [XLEN-3:0] l_addr;
  logic [XLEN-1:0] l_wdata;
  logic            l_last;
  logic            l_gnt;
  logic            l_rvalid;
  logic [XLEN-1:0] l_rdata;
  // IRAM port
  logic            iram_en;
  logic            iram_we;
  logic [XLEN-3:0] iram_addr;
  logic [XLEN-1:0] iram_wdata;
  logic [XLEN-1:0] iram_rdata;
  // Status
  logic            fetch_stall;

  modport slave (
    input  f_req, f_addr,
    input  l_req, l_we, l_addr, l_wdata, l_last,
    input  iram_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output iram_en, iram_we, iram_addr, iram_wdata,
    output fetch_stall
  );

  modport master (
    output f_req, f_addr,
    output l_req, l_we, l_addr, l_wdata, l_last,
    output iram_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  iram_en, iram_we, iram_addr, iram_wdata,
    input  fetch_stall
  );
endinterface

// File: rtl/iram_arbiter.sv
// iram_arbiter: shares one single-port IRAM between instruction fetch and a
// loader/debug port. Loader has priority and a multi-beat loader burst locks
// the port until its l_last beat. Read data returns one cycle after grant,
// steered to the requester recorded in a registered owner tag.
// Optional starvation guard: define IRAM_ARB_STARVE_EN to force one fetch
// slot after STARVE_MAX consecutive loader grants while fetch is waiting.
module iram_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  iram_arbiter_if.slave bus
);

  if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_starve_max
    $error("iram_arbiter: STARVE_MAX must be in 1..255");
  end

`ifdef IRAM_ARB_STARVE_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LOAD  = 2'd1,
    ST_YIELD = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LOAD  = 2'd1
  } state_e;
`endif

  state_e state_q, state_d;

  logic f_gnt;
  logic l_gnt;
  logic f_rvalid_q;
  logic l_rvalid_q;

`ifdef IRAM_ARB_STARVE_EN
  localparam logic [8:0] STARVE_LIM = 9'(STARVE_MAX);

  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       starve_hit;
`endif

  // State register, owner tag (read-return valids) and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
`ifdef IRAM_ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt & ~bus.l_we;
`ifdef IRAM_ARB_STARVE_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Grant decision and next state from current owner and requests
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.l_req) begin
          l_gnt = 1'b1;
          if (!bus.l_last) state_d = ST_LOAD;
        end else if (bus.f_req) begin
          f_gnt = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.l_req) begin
          l_gnt = 1'b1;
          if (bus.l_last) state_d = ST_FETCH;
        end
      end
`ifdef IRAM_ARB_STARVE_EN
      ST_YIELD: begin
        f_gnt   = bus.f_req;
        state_d = ST_LOAD;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
`ifdef IRAM_ARB_STARVE_EN
    // The grant that brings the waiting count to the limit schedules the
    // yield slot directly, so exactly STARVE_MAX beats precede each fetch slot.
    starve_hit = l_gnt & ~bus.l_last & bus.f_req &
                 (({1'b0, starve_cnt_q} + 9'd1) >= STARVE_LIM);
    if (starve_hit) state_d = ST_YIELD;
`endif
  end

`ifdef IRAM_ARB_STARVE_EN
  // Count loader grants while fetch waits; any fetch grant or idle fetch clears
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (f_gnt || !bus.f_req) begin
      starve_cnt_d = '0;
    end else if (l_gnt && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end
`endif

  // IRAM port mux from the granted requester
  always_comb begin
    bus.iram_en    = f_gnt | l_gnt;
    bus.iram_we    = l_gnt & bus.l_we;
    bus.iram_addr  = '0;
    bus.iram_wdata = '0;
    if (l_gnt) begin
      bus.iram_addr = bus.l_addr;
    end else if (f_gnt) begin
      bus.iram_addr = bus.f_addr;
    end
    if (l_gnt && bus.l_we) begin
      bus.iram_wdata = bus.l_wdata;
    end
  end

  assign bus.f_gnt       = f_gnt;
  assign bus.l_gnt       = l_gnt;
  assign bus.f_rvalid    = f_rvalid_q;
  assign bus.l_rvalid    = l_rvalid_q;
  assign bus.f_rdata     = bus.iram_rdata;
  assign bus.l_rdata     = bus.iram_rdata;
  assign bus.fetch_stall = bus.f_req & ~f_gnt;

endmodule
